phys_reg_free_list: RTL and testbench

//  Circular free list of physical registers, sitting between rename/dispatch and ROB retire.

---
 rtl/phys_reg_free_list_if.sv | 26 ++
 rtl/phys_reg_free_list.sv | 123 ++++++++++++
 tb/tb_phys_reg_free_list.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/phys_reg_free_list_if.sv
// Rename/retire handshake bundle for the physical register free list.
// master = rename/ROB side, slave = free list.
interface phys_reg_free_list_if #(
    parameter int PHY_WIDTH = 6
);
    logic                 flush;
    logic [1:0]           alloc_req;
    logic [1:0]           alloc_gnt;
    logic [PHY_WIDTH-1:0] alloc_phy_0;
    logic [PHY_WIDTH-1:0] alloc_phy_1;
    logic                 retire_pr_valid;
    logic [4:0]           rd_arch_commit;
    logic [PHY_WIDTH-1:0] rd_phy_old_commit;
    logic [PHY_WIDTH-1:0] free_count;
    logic                 fl_empty;

    modport master (
        output flush, alloc_req, retire_pr_valid, rd_arch_commit, rd_phy_old_commit,
        input  alloc_gnt, alloc_phy_0, alloc_phy_1, free_count, fl_empty
    );

    modport slave (
        input  flush, alloc_req, retire_pr_valid, rd_arch_commit, rd_phy_old_commit,
        output alloc_gnt, alloc_phy_0, alloc_phy_1, free_count, fl_empty
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular physical register free list: 2-wide allocation, 1-wide release, one-cycle flush recovery.
// Define FREELIST_CHECK_EN to add an in_free bitmap with protocol/consistency $error checks.
module phys_reg_free_list #(
    parameter int NUM_PHY_REG  = 64,
    parameter int NUM_ARCH_REG = 32,
    parameter int PHY_WIDTH    = $clog2(NUM_PHY_REG),
    parameter int FL_DEPTH     = NUM_PHY_REG - NUM_ARCH_REG
) (
    input logic                 clk,
    input logic                 rst,
    phys_reg_free_list_if.slave bus
);
    localparam int IW = $clog2(FL_DEPTH);
    localparam int PW = IW + 1;

    logic [PHY_WIDTH-1:0] ring_q [FL_DEPTH];
    logic [PW-1:0]        alloc_ptr_q, commit_ptr_q, tail_q;
    logic [PW-1:0]        alloc_ptr_d, commit_ptr_d, tail_d;
    logic [PW-1:0]        count;
    logic [1:0]           need, gnt, n_gnt;
    logic [IW-1:0]        idx0, idx1;
    logic                 full, retire_en;
    logic [PHY_WIDTH-1:0] phy_0, phy_1;

    assign count = tail_q - alloc_ptr_q;
    assign full  = (count == PW'(FL_DEPTH));
    assign need  = {1'b0, bus.alloc_req[0]} + {1'b0, bus.alloc_req[1]};
    // All-or-nothing grant; a flush cycle never grants.
    assign gnt   = (!bus.flush && (PW'(need) <= count)) ? bus.alloc_req : 2'b00;
    assign n_gnt = {1'b0, gnt[0]} + {1'b0, gnt[1]};
    assign idx0  = alloc_ptr_q[IW-1:0];
    assign idx1  = idx0 + IW'(1);

    // Releasing into a full ring is a protocol error; the whole retire is dropped.
    assign retire_en = bus.retire_pr_valid && (bus.rd_arch_commit != 5'd0) && !full;

    always_comb begin
        phy_0 = '0;
        phy_1 = '0;
        case (gnt)
            2'b11: begin
                phy_0 = ring_q[idx0];
                phy_1 = ring_q[idx1];
            end
            2'b01:   phy_0 = ring_q[idx0];
            2'b10:   phy_1 = ring_q[idx0];
            default: ;
        endcase
    end

    assign bus.alloc_gnt   = gnt;
    assign bus.alloc_phy_0 = phy_0;
    assign bus.alloc_phy_1 = phy_1;
    assign bus.free_count  = PHY_WIDTH'(count);
    assign bus.fl_empty    = (count == '0);

    always_comb begin
        commit_ptr_d = commit_ptr_q + PW'(retire_en);
        tail_d       = tail_q + PW'(retire_en);
        alloc_ptr_d  = bus.flush ? commit_ptr_d : alloc_ptr_q + PW'(n_gnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr_q  <= '0;
            commit_ptr_q <= '0;
            tail_q       <= PW'(FL_DEPTH);
            for (int i = 0; i < FL_DEPTH; i++) begin
                ring_q[i] <= PHY_WIDTH'(NUM_ARCH_REG + i);
            end
        end else begin
            alloc_ptr_q  <= alloc_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            tail_q       <= tail_d;
            if (retire_en) begin
                ring_q[tail_q[IW-1:0]] <= bus.rd_phy_old_commit;
            end
        end
    end

`ifdef FREELIST_CHECK_EN
    logic [NUM_PHY_REG-1:0] in_free_q, in_free_d;

    always_comb begin
        in_free_d = in_free_q;
        if (bus.flush) begin
            // Rebuild from the committed window, including this cycle's push.
            in_free_d = '0;
            for (int k = 0; k < FL_DEPTH; k++) begin
                if (PW'(k) < PW'(tail_d - commit_ptr_d)) begin
                    if (retire_en && ((commit_ptr_d[IW-1:0] + IW'(k)) == tail_q[IW-1:0])) begin
                        in_free_d[bus.rd_phy_old_commit] = 1'b1;
                    end else begin
                        in_free_d[ring_q[commit_ptr_d[IW-1:0] + IW'(k)]] = 1'b1;
                    end
                end
            end
        end else begin
            if (gnt[0]) in_free_d[phy_0] = 1'b0;
            if (gnt[1]) in_free_d[phy_1] = 1'b0;
            if (retire_en) in_free_d[bus.rd_phy_old_commit] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PHY_REG; i++) begin
                in_free_q[i] <= (i >= NUM_ARCH_REG);
            end
        end else begin
            in_free_q <= in_free_d;
            if (gnt[0] && !in_free_q[phy_0]) $error("free list: p%0d allocated twice", phy_0);
            if (gnt[1] && !in_free_q[phy_1]) $error("free list: p%0d allocated twice", phy_1);
            if (bus.retire_pr_valid && (bus.rd_arch_commit != 5'd0)) begin
                if (full) $error("free list: release while full");
                if (bus.rd_phy_old_commit == '0) $error("free list: release of p0");
                else if (in_free_q[bus.rd_phy_old_commit])
                    $error("free list: p%0d released while already free", bus.rd_phy_old_commit);
            end
        end
    end
`endif
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Randomised bench for phys_reg_free_list against a queue-based free-list model.
module tb_phys_reg_free_list;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    phys_reg_free_list_if #(.PHY_WIDTH(6)) bus ();

    phys_reg_free_list dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // fl holds PRs from the committed point to the tail; the first spec entries are in flight.
    int fl[$];
    int spec;
    int cmap[32];

    int g_gnt, g_phy0, g_phy1, g_free, g_empty;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        for (int i = 0; i < 32; i++) fl.push_back(32 + i);
        spec = 0;
        for (int i = 0; i < 32; i++) cmap[i] = i;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.alloc_req = 2'b00;
        bus.retire_pr_valid = 1'b0;
        bus.rd_arch_commit = 5'd0;
        bus.rd_phy_old_commit = 6'd0;
        #1;
        model_reset();
        check_eq("rst_free", int'(bus.free_count), 32);
        check_eq("rst_empty", int'(bus.fl_empty), 0);
        check_eq("rst_gnt", int'(bus.alloc_gnt), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input bit f, input bit [1:0] req, input bit rv, input int rd, input int old);
        int free, need, egnt, ep0, ep1;
        bit ret;
        @(negedge clk);
        bus.flush = f;
        bus.alloc_req = req;
        bus.retire_pr_valid = rv;
        bus.rd_arch_commit = 5'(rd);
        bus.rd_phy_old_commit = 6'(old);
        #1;
        free = fl.size() - spec;
        need = int'(req[0]) + int'(req[1]);
        egnt = (!f && need <= free) ? int'(req) : 0;
        ep0 = 0;
        ep1 = 0;
        if (egnt == 3) begin
            ep0 = fl[spec];
            ep1 = fl[spec + 1];
        end else if (egnt == 1) begin
            ep0 = fl[spec];
        end else if (egnt == 2) begin
            ep1 = fl[spec];
        end
        g_gnt = int'(bus.alloc_gnt);
        g_phy0 = int'(bus.alloc_phy_0);
        g_phy1 = int'(bus.alloc_phy_1);
        g_free = int'(bus.free_count);
        g_empty = int'(bus.fl_empty);
        check_eq("gnt", g_gnt, egnt);
        check_eq("phy0", g_phy0, ep0);
        check_eq("phy1", g_phy1, ep1);
        check_eq("free_count", g_free, free);
        check_eq("fl_empty", g_empty, int'(free == 0));
        @(posedge clk);
        ret = rv && (rd != 0) && (free != 32);
        spec += (egnt == 3) ? 2 : (egnt != 0 ? 1 : 0);
        if (ret) begin
            void'(fl.pop_front());
            fl.push_back(old);
            spec -= 1;
        end
        if (f) spec = 0;
    endtask

    // Legal retire of the oldest in-flight writer to arch reg rd; returns the stale PR.
    function automatic int commit_old(input int rd);
        int old;
        old = cmap[rd];
        cmap[rd] = fl[0];
        return old;
    endfunction

    initial begin
        bus.flush = 1'b0;
        bus.alloc_req = 2'b00;
        bus.retire_pr_valid = 1'b0;
        bus.rd_arch_commit = 5'd0;
        bus.rd_phy_old_commit = 6'd0;

        // Basic pair allocation right after reset
        do_reset();
        step(0, 2'b11, 0, 0, 0);
        check_eq("t1_gnt", g_gnt, 3);
        check_eq("t1_phy0", g_phy0, 32);
        check_eq("t1_phy1", g_phy1, 33);
        step(0, 2'b00, 0, 0, 0);
        check_eq("t1_free", g_free, 30);

        // Drain to empty, then a single request must be refused
        for (int i = 0; i < 15; i++) step(0, 2'b11, 0, 0, 0);
        step(0, 2'b01, 0, 0, 0);
        check_eq("t2_free", g_free, 0);
        check_eq("t2_empty", g_empty, 1);
        check_eq("t2_gnt", g_gnt, 0);
        check_eq("t2_phy0", g_phy0, 0);

        // One free entry: pair request refused; released PR usable next cycle
        step(0, 2'b00, 1, 5, commit_old(5));
        step(0, 2'b11, 1, 5, 7);
        check_eq("t3_free1", g_free, 1);
        check_eq("t3_gnt", g_gnt, 0);
        step(0, 2'b11, 0, 0, 0);
        check_eq("t3_free2", g_free, 2);
        check_eq("t3_gnt2", g_gnt, 3);
        check_eq("t3_phy1", g_phy1, 7);

        // Flush with same-cycle retire recovers all speculative allocations
        do_reset();
        step(0, 2'b11, 0, 0, 0);
        step(0, 2'b01, 0, 0, 0);
        step(1, 2'b11, 1, 3, commit_old(3));
        check_eq("t4_flush_gnt", g_gnt, 0);
        step(0, 2'b01, 0, 0, 0);
        check_eq("t4_free", g_free, 32);
        check_eq("t4_phy_a", g_phy0, 33);
        step(0, 2'b01, 0, 0, 0);
        check_eq("t4_phy_b", g_phy0, 34);

        // Retire to x0 is ignored
        do_reset();
        step(0, 2'b01, 0, 0, 0);
        step(0, 2'b00, 1, 0, 9);
        step(0, 2'b00, 0, 0, 0);
        check_eq("t6_free", g_free, 31);

        // Steady-state wrap: one alloc and one retire per cycle
        do_reset();
        step(0, 2'b01, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            int rd;
            rd = int'($urandom_range(31, 1));
            step(0, 2'b01, 1, rd, commit_old(rd));
        end
        check_eq("t5_free_steady", g_free, 31);
        begin
            int rd;
            rd = int'($urandom_range(31, 1));
            step(0, 2'b00, 1, rd, commit_old(rd));
        end
        step(0, 2'b00, 0, 0, 0);
        check_eq("t5_free_full", g_free, 32);

        // Random traffic, with an asynchronous reset in the middle
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bit f, rv;
            bit [1:0] req;
            int rd, old;
            if (c == 300) do_reset();
            f = ($urandom_range(15, 0) == 0);
            req = 2'($urandom_range(3, 0));
            rv = (spec > 0) && ($urandom_range(1, 0) == 1);
            rd = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(31, 1));
            if (rv && rd != 0) old = commit_old(rd);
            else old = int'($urandom_range(63, 1));
            step(f, req, rv, rd, old);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
